fwft_sc_fifo_v2: RTL and testbench
==================================

FWFT_SC_FIFO_V2 -- requirements
Module: fwft_sc_fifo_v2

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, total word capacity; power of two, at least 4.
REQ-002 SHALL have parameter WIDTH, default 8, data bits per word.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-1; afull asserts when count >= AFULL_LVL.
REQ-004 SHALL have parameter AEMPTY_LVL, default 1; aempty asserts when count <= AEMPTY_LVL.
REQ-005 SHALL have localparam CW = $clog2(DEPTH+1).
REQ-006 clk  in  1  clock; all logic on the rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-low.
REQ-008 flush  in  1  synchronous empty request.
REQ-009 wren  in  1  write request.
REQ-010 wdata  in  WIDTH  write data.
REQ-011 full  out  1  count == DEPTH.
REQ-012 afull  out  1  almost full.
REQ-013 rden  in  1  pop the word currently on rdata.
REQ-014 rdata  out  WIDTH  head-of-queue word, valid when rdata_vld = 1.
REQ-015 rdata_vld  out  1  rdata holds an unread word.
REQ-016 aempty  out  1  almost empty.
REQ-017 count  out  CW  words held, including the output stage.
REQ-018 overflow  out  1  sticky: write attempted while full.
REQ-019 underflow  out  1  sticky: read attempted while rdata_vld = 0.

Function
REQ-020 Storage SHALL be a simple dual-port RAM with a registered read, plus a first-word-fall-through output register; total capacity SHALL be exactly DEPTH words.
REQ-021 A write SHALL be accepted on an edge where wren = 1 and full = 0; wdata is stored in arrival order.
REQ-022 wren = 1 with full = 1 SHALL drop the word and set overflow; this holds even if rden = 1 on the same edge.
REQ-023 A read SHALL be accepted on an edge where rden = 1 and rdata_vld = 1; the next word (if any) SHALL appear on rdata with no idle cycle under sustained read.
REQ-024 rden = 1 with rdata_vld = 0 SHALL be ignored and set underflow.
REQ-025 Latency: a word written into an empty FIFO at edge N SHALL be on rdata with rdata_vld = 1 after edge N+2.
REQ-026 count SHALL update on the edge of every accepted write and read: +1, -1, or unchanged when both occur; full, afull and aempty are registered-equivalent with count.
REQ-027 Simultaneous accepted read and write SHALL be allowed at any fill level, including count = 1 and count = DEPTH-1.
REQ-028 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap or duplicate.
REQ-029 rdata SHALL hold its value while rden = 0; it is don't-care while rdata_vld = 0.
REQ-030 flush = 1 SHALL, on that edge, set count to 0, zero both pointers, drop rdata_vld and clear overflow and underflow; wren and rden on that edge are ignored.
REQ-031 overflow and underflow SHALL stay set until flush or reset.

Reset
REQ-032 While rst = 0, asynchronously: pointers = 0, count = 0, full = 0, afull = 0 (or 1 if AFULL_LVL = 0), aempty = 1, rdata_vld = 0, overflow = 0, underflow = 0, rdata = 0.
REQ-033 Reset asserted mid-operation SHALL discard all contents; RAM contents need not be cleared.
REQ-034 The first write SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-035 Fill then drain: write 0..1023 with DEPTH = 1024 and rden held 0 -> full = 1 and count = 1024 after the 1024th write; afull asserts at count = 1023; then read continuously -> rdata is 0..1023 in order, no idle cycles, aempty asserts at count = 1.
REQ-036 Latency: single write of 0xA5 into an empty FIFO -> rdata_vld = 1 and rdata = 0xA5 exactly 2 edges later; count = 1 one edge after the write.
REQ-037 Overflow: with the FIFO full, wren = 1 and rden = 1 with wdata = 0x77 -> 0x77 is dropped, overflow = 1, count = 1023; a later full drain never returns 0x77.
REQ-038 Underflow and flush: rden = 1 on an empty FIFO -> underflow = 1 and count stays 0; then write 3 words and pulse flush -> count = 0, rdata_vld = 0, underflow = 0.
REQ-039 Streaming and wrap: rden <= rdata_vld while writing an incrementing byte every cycle for 3000 cycles -> every value is read exactly once in order across pointer wrap, count <= 3.
REQ-040 Reset mid-stream: assert rst with count = 500 -> all outputs take their REQ-032 values immediately, before the next clock edge; after release, a write of 0x11 reads back as 0x11.

Source files
------------

// File: rtl/fwft_sc_fifo_v2.sv
// Single-clock first-word-fall-through FIFO.
// Storage is a simple dual-port RAM with a registered read port. A prefetch
// stage (mid) holds the RAM read result and feeds the output register
// (rdata / rdata_vld). The count includes the RAM, prefetch and output stages,
// so the total capacity is exactly DEPTH words.
module fwft_sc_fifo_v2 #(
    parameter int DEPTH      = 1024,
    parameter int WIDTH      = 8,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wren,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             afull,
    input  logic             rden,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_vld,
    output logic             aempty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, afull_q, aempty_q;
    logic             mid_vld_q, mid_vld_d;
    logic [WIDTH-1:0] mid_data_q;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_acc, rd_acc;
    logic             mid_move, mid_ready, rd_issue;
    logic [CW-1:0]    ram_words;

    // Handshake decode and pipeline movement between RAM, prefetch and output.
    always_comb begin
        wr_acc    = wren && !full_q && !flush;
        rd_acc    = rden && out_vld_q && !flush;
        // Words still sitting in the RAM, not yet pulled into mid or out.
        ram_words = count_q - CW'(mid_vld_q) - CW'(out_vld_q);
        // Output register accepts a new word when empty or being popped.
        mid_move  = mid_vld_q && (!out_vld_q || rd_acc) && !flush;
        mid_ready = !mid_vld_q || mid_move;
        rd_issue  = (ram_words != '0) && mid_ready && !flush;
    end

    // Next-state for pointers, count, stage valids and sticky error flags.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        mid_vld_d = mid_vld_q;
        out_vld_d = out_vld_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            mid_vld_d = 1'b0;
            out_vld_d = 1'b0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end else begin
            if (wr_acc)   wptr_d = wptr_q + 1'b1;
            if (rd_issue) rptr_d = rptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (rd_issue)      mid_vld_d = 1'b1;
            else if (mid_move) mid_vld_d = 1'b0;
            if (mid_move)      out_vld_d = 1'b1;
            else if (rd_acc)   out_vld_d = 1'b0;
            if (wren && full_q)      ovf_d = 1'b1;
            if (rden && !out_vld_q)  udf_d = 1'b1;
        end
    end

    // Control state; status flags are registered from the next count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= (AFULL_LVL == 0);
            aempty_q   <= 1'b1;
            mid_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            full_q    <= (count_d == CW'(DEPTH));
            afull_q   <= (count_d >= CW'(AFULL_LVL));
            aempty_q  <= (count_d <= CW'(AEMPTY_LVL));
            mid_vld_q <= mid_vld_d;
            out_vld_q <= out_vld_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            if (mid_move) out_data_q <= mid_data_q;
        end
    end

    // RAM write port and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_acc)   mem[wptr_q] <= wdata;
        if (rd_issue) mid_data_q  <= mem[rptr_q];
    end

    assign full      = full_q;
    assign afull     = afull_q;
    assign aempty    = aempty_q;
    assign count     = count_q;
    assign rdata     = out_data_q;
    assign rdata_vld = out_vld_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_fwft_sc_fifo_v2.sv
// Directed self-checking bench for fwft_sc_fifo_v2 (DEPTH=1024, WIDTH=8).
module tb_fwft_sc_fifo_v2;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             wren = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             rden = 1'b0;
    logic             full, afull, aempty, rdata_vld, overflow, underflow;
    logic [WIDTH-1:0] rdata;
    logic [CW-1:0]    count;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_rd;

    fwft_sc_fifo_v2 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wren(wren), .wdata(wdata),
        .full(full), .afull(afull), .rden(rden), .rdata(rdata),
        .rdata_vld(rdata_vld), .aempty(aempty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are examined 1 ns after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_count"}, count, 0);
        chk({pfx, "_full"}, full, 0);
        chk({pfx, "_afull"}, afull, 0);
        chk({pfx, "_aempty"}, aempty, 1);
        chk({pfx, "_vld"}, rdata_vld, 0);
        chk({pfx, "_ovf"}, overflow, 0);
        chk({pfx, "_udf"}, underflow, 0);
        chk({pfx, "_rdata"}, rdata, 0);
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk_reset_vals("rst");
        #2 rst = 1'b1;

        // Latency: first edge after reset release accepts the write
        wren = 1'b1; wdata = 8'hA5;
        tick;
        wren = 1'b0;
        chk("lat_cnt1", count, 1);
        chk("lat_vld_n", rdata_vld, 0);
        tick;
        chk("lat_vld_n1", rdata_vld, 0);
        tick;
        chk("lat_vld_n2", rdata_vld, 1);
        chk("lat_data", rdata, 8'hA5);
        tick;
        chk("hold_data", rdata, 8'hA5);
        rden = 1'b1;
        tick;
        rden = 1'b0;
        chk("lat_pop_cnt", count, 0);
        chk("lat_pop_vld", rdata_vld, 0);

        // Underflow then flush
        rden = 1'b1;
        tick;
        rden = 1'b0;
        chk("udf_set", underflow, 1);
        chk("udf_cnt", count, 0);
        for (int i = 0; i < 3; i++) begin
            wren = 1'b1; wdata = 8'h30 + i[7:0];
            tick;
        end
        wren = 1'b0;
        chk("pre_flush_cnt", count, 3);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_cnt", count, 0);
        chk("flush_vld", rdata_vld, 0);
        chk("flush_udf", underflow, 0);
        tick; tick; tick;
        chk("flush_vld_late", rdata_vld, 0);

        // Fill 0..1023
        for (int i = 0; i < DEPTH; i++) begin
            wren = 1'b1; wdata = i[7:0];
            tick;
            if (i + 1 == DEPTH - 2) chk("afull_1022", afull, 0);
            if (i + 1 == DEPTH - 1) begin
                chk("afull_1023", afull, 1);
                chk("full_1023", full, 0);
            end
        end
        wren = 1'b0;
        chk("full_set", full, 1);
        chk("full_cnt", count, DEPTH);
        chk("full_head", rdata, 0);
        chk("full_head_vld", rdata_vld, 1);

        // Overflow with simultaneous read
        wren = 1'b1; rden = 1'b1; wdata = 8'h77;
        tick;
        wren = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_cnt", count, DEPTH - 1);
        chk("ovf_full", full, 0);

        // Continuous drain of 1..1023 with no idle cycle
        for (int k = 1; k < DEPTH; k++) begin
            chk("drain_vld", rdata_vld, 1);
            chk("drain_data", rdata, k[7:0]);
            chk("drain_cnt", count, DEPTH - k);
            chk("drain_aempty", aempty, (DEPTH - k) <= 1);
            tick;
        end
        rden = 1'b0;
        chk("drain_end_cnt", count, 0);
        chk("drain_end_vld", rdata_vld, 0);
        chk("ovf_sticky", overflow, 1);

        // Streaming across pointer wrap
        exp_rd = 0;
        for (int i = 0; i < 3000; i++) begin
            wren = 1'b1; wdata = i[7:0];
            rden = rdata_vld;
            if (rdata_vld) begin
                chk("stream_data", rdata, exp_rd & 8'hFF);
                exp_rd++;
            end
            tick;
            chk("stream_cnt_le3", count <= 3, 1);
        end
        wren = 1'b0;
        for (int j = 0; j < 10; j++) begin
            rden = rdata_vld;
            if (rdata_vld) begin
                chk("stream_data", rdata, exp_rd & 8'hFF);
                exp_rd++;
            end
            tick;
        end
        rden = 1'b0;
        chk("stream_total", exp_rd, 3000);
        chk("stream_empty", count, 0);

        // Reset mid-stream
        for (int i = 0; i < 500; i++) begin
            wren = 1'b1; wdata = i[7:0];
            tick;
        end
        wren = 1'b0;
        chk("pre_rst_cnt", count, 500);
        chk("pre_rst_ovf", overflow, 1);
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        #2 rst = 1'b1;
        wren = 1'b1; wdata = 8'h11;
        tick;
        wren = 1'b0;
        chk("post_rst_cnt", count, 1);
        tick; tick;
        chk("post_rst_vld", rdata_vld, 1);
        chk("post_rst_data", rdata, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
